// File: rtl/cache_pkg.sv
// Shared cache geometry and refill FSM types, imported by the cache and its refill unit.
package cache_pkg;
  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 64;
  localparam int BLOCK_WORDS = 4;
  localparam int OFF_W       = $clog2(BLOCK_WORDS);

  typedef logic [WORD_W*BLOCK_WORDS-1:0] cache_line_t;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_REQ,
    RF_WAIT,
    RF_DONE
  } refill_state_t;
endpackage

// File: rtl/cache_refill_unit.sv
// Miss-path line fetcher: reads one block from memory critical-word-first,
// forwards the critical word early and returns the assembled line to the cache.
module cache_refill_unit
  import cache_pkg::*;
#(
  parameter int ADDR_W      = cache_pkg::ADDR_W,
  parameter int WORD_W      = cache_pkg::WORD_W,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          refill_req,
  input  logic [ADDR_W-1:0]             refill_addr,
  output logic                          refill_ready,
  output logic                          crit_valid,
  output logic [WORD_W-1:0]             crit_data,
  output logic                          refill_done,
  output logic [WORD_W*BLOCK_WORDS-1:0] refill_line,
  output logic [ADDR_W-1:0]             refill_base,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  input  logic                          mem_rsp_valid,
  input  logic [WORD_W-1:0]             mem_rsp_data
);
  localparam int L_OFF_W = $clog2(BLOCK_WORDS);

  refill_state_t                 r_state;
  logic [L_OFF_W-1:0]            r_off;
  logic [L_OFF_W-1:0]            r_cnt;
  logic [ADDR_W-1:0]             r_base;
  logic [WORD_W*BLOCK_WORDS-1:0] r_line;
  logic                          r_ready;
  logic                          r_critValid;
  logic [WORD_W-1:0]             r_critData;
  logic                          r_done;
  logic                          r_reqValid;
  logic [ADDR_W-1:0]             r_reqAddr;

  logic [L_OFF_W-1:0]            w_slot;
  logic [L_OFF_W-1:0]            w_nextSlot;
  logic                          w_lastWord;
  logic [ADDR_W-1:0]             w_acceptBase;

  // Slot arithmetic wraps naturally in L_OFF_W bits, keeping every read inside the block.
  assign w_slot       = r_off + r_cnt;
  assign w_nextSlot   = w_slot + L_OFF_W'(1);
  assign w_lastWord   = (r_cnt == L_OFF_W'(BLOCK_WORDS - 1));
  assign w_acceptBase = refill_addr & ~ADDR_W'(BLOCK_WORDS - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RF_IDLE;
      r_off       <= '0;
      r_cnt       <= '0;
      r_base      <= '0;
      r_line      <= '0;
      r_ready     <= 1'b1;
      r_critValid <= 1'b0;
      r_critData  <= '0;
      r_done      <= 1'b0;
      r_reqValid  <= 1'b0;
      r_reqAddr   <= '0;
    end else begin
      r_critValid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        RF_IDLE: begin
          if (refill_req) begin
            r_base     <= w_acceptBase;
            r_off      <= refill_addr[L_OFF_W-1:0];
            r_cnt      <= '0;
            r_reqAddr  <= refill_addr;
            r_reqValid <= 1'b1;
            r_ready    <= 1'b0;
            r_state    <= RF_REQ;
          end
        end
        RF_REQ: begin
          if (mem_req_ready) begin
            r_reqValid <= 1'b0;
            r_state    <= RF_WAIT;
          end
        end
        RF_WAIT: begin
          // Responses are only honoured here, so stale or early data never reaches the line.
          if (mem_rsp_valid) begin
            r_line[w_slot*WORD_W +: WORD_W] <= mem_rsp_data;
            if (r_cnt == '0) begin
              r_critValid <= 1'b1;
              r_critData  <= mem_rsp_data;
            end
            r_cnt <= r_cnt + L_OFF_W'(1);
            if (w_lastWord) begin
              r_done  <= 1'b1;
              r_state <= RF_DONE;
            end else begin
              r_reqValid <= 1'b1;
              r_reqAddr  <= r_base | ADDR_W'(w_nextSlot);
              r_state    <= RF_REQ;
            end
          end
        end
        RF_DONE: begin
          r_ready <= 1'b1;
          r_state <= RF_IDLE;
        end
        default: begin
          r_state <= RF_IDLE;
        end
      endcase
    end
  end

  assign refill_ready  = r_ready;
  assign crit_valid    = r_critValid;
  assign crit_data     = r_critData;
  assign refill_done   = r_done;
  assign refill_line   = r_line;
  assign refill_base   = r_base;
  assign mem_req_valid = r_reqValid;
  assign mem_req_addr  = r_reqAddr;
endmodule

// File: tb/tb_cache_refill_unit.sv
// Self-checking bench for cache_refill_unit: directed scenarios plus randomized
// refills, checked against a block-level memory/line model.
module tb_cache_refill_unit;
  localparam int AW = 32;
  localparam int WW = 64;
  localparam int BW = 4;

  logic             clock;
  logic             reset;
  logic             refill_req;
  logic [AW-1:0]    refill_addr;
  logic             refill_ready;
  logic             crit_valid;
  logic [WW-1:0]    crit_data;
  logic             refill_done;
  logic [WW*BW-1:0] refill_line;
  logic [AW-1:0]    refill_base;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [AW-1:0]    mem_req_addr;
  logic             mem_rsp_valid;
  logic [WW-1:0]    mem_rsp_data;

  int checksDone;
  int checksPassed;
  int stallPlan[4];
  int latPlan[4];

  cache_refill_unit dut (
    .clock        (clock),
    .reset        (reset),
    .refill_req   (refill_req),
    .refill_addr  (refill_addr),
    .refill_ready (refill_ready),
    .crit_valid   (crit_valid),
    .crit_data    (crit_data),
    .refill_done  (refill_done),
    .refill_line  (refill_line),
    .refill_base  (refill_base),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checksDone++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  // Memory content model: every word holds three times its address.
  function automatic logic [63:0] memWord(input logic [31:0] a);
    return {32'd0, a} * 64'd3;
  endfunction

  function automatic logic [255:0] expLine(input logic [31:0] a);
    logic [255:0] line;
    logic [31:0]  b;
    b = a & ~32'd3;
    line = '0;
    for (int k = 0; k < 4; k++) line[k*64 +: 64] = memWord(b + 32'(k));
    return line;
  endfunction

  task automatic setPlan(input int s0, input int s1, input int s2, input int s3,
                         input int l0, input int l1, input int l2, input int l3);
    stallPlan[0] = s0; stallPlan[1] = s1; stallPlan[2] = s2; stallPlan[3] = s3;
    latPlan[0] = l0;   latPlan[1] = l1;   latPlan[2] = l2;   latPlan[3] = l3;
  endtask

  // One refill, cycle by cycle from the negedge; abortAfter>0 asserts reset after that many responses.
  task automatic applyStimulus(input logic [31:0] addr, input bit holdReq, input bit spurious,
                               input int abortAfter, input int fixedDone);
    int          cyc, reqIdx, stallLeft, rspCyc, rspCount, firstRspCyc, critCount, modelDone;
    bit          inReq, rspPending, finished;
    logic [31:0] heldAddr, pendAddr, base, expAddr;
    base = addr & ~32'd3;
    modelDone = 1;
    for (int w = 0; w < 4; w++) modelDone += 1 + stallPlan[w] + latPlan[w];
    reqIdx = 0; stallLeft = 0; rspCyc = 0; rspCount = 0; firstRspCyc = 0; critCount = 0;
    inReq = 0; rspPending = 0; finished = 0; heldAddr = '0; pendAddr = '0;

    @(negedge clock);
    if (spurious) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge clock);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    checkOutput("ready_idle", refill_ready, 1'b1);
    refill_req  = 1'b1;
    refill_addr = addr;
    @(negedge clock);
    refill_req  = holdReq;
    refill_addr = addr ^ 32'h40;
    cyc = 1;

    while (!finished) begin
      if (abortAfter > 0 && rspCount == abortAfter) begin
        reset         = 1'b1;
        refill_req    = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        finished      = 1;
      end else begin
        checkOutput("busy_not_ready", refill_ready, 1'b0);
        if (crit_valid) begin
          critCount++;
          checkOutput("crit_data", crit_data, memWord(addr));
          checkOutput("crit_timing", 32'(cyc), 32'(firstRspCyc + 1));
        end
        if (refill_done) begin
          checkOutput("done_cycle", 32'(cyc), 32'(modelDone));
          if (fixedDone > 0) checkOutput("done_fixed", 32'(cyc), 32'(fixedDone));
          checkOutput("line", refill_line, expLine(addr));
          checkOutput("base", refill_base, base);
          checkOutput("crit_count", 32'(critCount), 32'd1);
          checkOutput("req_count", 32'(reqIdx), 32'd4);
          refill_req    = 1'b0;
          mem_rsp_valid = 1'b0;
          mem_req_ready = 1'b0;
          finished      = 1;
        end else if (cyc > 200) begin
          checkOutput("timeout", 1'b0, 1'b1);
          reset = 1'b1;
          refill_req = 1'b0;
          @(negedge clock);
          reset = 1'b0;
          finished = 1;
        end else begin
          mem_rsp_valid = 1'b0;
          mem_rsp_data  = '0;
          if (rspPending && cyc == rspCyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = memWord(pendAddr);
            rspPending = 0;
            rspCount++;
            if (rspCount == 1) firstRspCyc = cyc;
          end
          mem_req_ready = 1'b0;
          if (inReq) begin
            checkOutput("req_valid_hold", mem_req_valid, 1'b1);
            checkOutput("req_addr_hold", mem_req_addr, heldAddr);
          end else if (mem_req_valid) begin
            inReq     = 1;
            heldAddr  = mem_req_addr;
            stallLeft = (reqIdx < 4) ? stallPlan[reqIdx] : 0;
            expAddr   = base + 32'((int'(addr & 32'd3) + reqIdx) % 4);
            checkOutput("req_addr", mem_req_addr, expAddr);
          end
          if (inReq) begin
            if (stallLeft > 0) stallLeft--;
            else begin
              mem_req_ready = 1'b1;
              inReq      = 0;
              rspPending = 1;
              rspCyc     = cyc + ((reqIdx < 4) ? latPlan[reqIdx] : 1);
              pendAddr   = heldAddr;
              reqIdx++;
            end
          end
          if (spurious && mem_req_valid && !mem_rsp_valid) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
          end
        end
      end
      if (!finished) begin
        @(negedge clock);
        cyc++;
      end
    end

    if (abortAfter == 0) begin
      @(negedge clock);
      checkOutput("done_pulse", refill_done, 1'b0);
      checkOutput("ready_after", refill_ready, 1'b1);
      checkOutput("no_reaccept", mem_req_valid, 1'b0);
      checkOutput("line_held", refill_line, expLine(addr));
    end
  endtask

  initial begin
    bit sawBad;
    checksDone   = 0;
    checksPassed = 0;
    reset         = 1'b1;
    refill_req    = 1'b0;
    refill_addr   = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_ready", refill_ready, 1'b1);
    checkOutput("rst_valid", {crit_valid, refill_done, mem_req_valid}, 3'b000);
    checkOutput("rst_data", {crit_data, refill_base, mem_req_addr}, '0);
    checkOutput("rst_line", refill_line, '0);
    reset = 1'b0;

    $display("[TB] aligned refill");
    setPlan(0, 0, 0, 0, 1, 1, 1, 1);
    applyStimulus(32'h100, 0, 0, 0, 9);

    $display("[TB] wrapped refill");
    applyStimulus(32'h203, 0, 0, 0, 9);

    $display("[TB] backpressure");
    setPlan(0, 5, 0, 0, 1, 3, 1, 1);
    applyStimulus(32'h100, 0, 0, 0, 16);

    $display("[TB] busy request and spurious responses");
    setPlan(0, 2, 0, 1, 1, 1, 2, 1);
    applyStimulus(32'h341, 1, 1, 0, 0);

    $display("[TB] reset mid-refill");
    setPlan(0, 0, 0, 0, 1, 1, 1, 1);
    applyStimulus(32'h180, 0, 0, 2, 0);
    @(negedge clock);
    reset      = 1'b0;
    refill_req = 1'b0;
    checkOutput("abort_ready", refill_ready, 1'b1);
    checkOutput("abort_valid", {mem_req_valid, refill_done}, 2'b00);
    checkOutput("abort_base", refill_base, '0);
    checkOutput("abort_line", refill_line, '0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h1234_5678_9ABC_DEF0;
    sawBad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      mem_rsp_valid = 1'b0;
      sawBad |= refill_done | crit_valid | mem_req_valid | ~refill_ready;
    end
    checkOutput("late_rsp_ignored", sawBad, 1'b0);
    checkOutput("late_rsp_line", refill_line, '0);
    applyStimulus(32'h100, 0, 0, 0, 9);

    $display("[TB] address wrap at top of memory");
    applyStimulus(32'hFFFF_FFFE, 0, 0, 0, 9);

    $display("[TB] randomized refills");
    for (int t = 0; t < 10; t++) begin
      for (int w = 0; w < 4; w++) begin
        stallPlan[w] = int'($urandom_range(0, 3));
        latPlan[w]   = int'($urandom_range(1, 4));
      end
      applyStimulus($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end
endmodule

// File: doc/cache_refill_unit.md
Name: cache_refill_unit

Overview:
- Miss-path line fetcher between the 8-way cache and main memory; it supplies the cache's refill data.
- The cache hands it a missing word address. The block issues 4 single-word reads to main memory, critical word first with wrap-around inside the 4-word block.
- It forwards the critical word early, assembles the 256-bit line in address order, and returns it to the cache with a one-cycle done pulse.
- One refill in flight at a time; one memory read outstanding at a time.

Parameters:
- ADDR_W, 32, word address width; memory is word-addressed and address+1 is the next 64-bit word.
- WORD_W, 64, data word width.
- BLOCK_WORDS, 4, words per cache block; must be a power of 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- refill_req  in  1  cache requests a refill; accepted when refill_req && refill_ready.
- refill_addr  in  ADDR_W  missing word address; sampled on accept.
- refill_ready  out  1  high only in IDLE.
- crit_valid  out  1  one-cycle pulse; crit_data holds the requested word.
- crit_data  out  WORD_W  critical word.
- refill_done  out  1  one-cycle pulse; refill_line and refill_base are valid.
- refill_line  out  WORD_W*BLOCK_WORDS  bits [64k+63:64k] hold the word at refill_base+k.
- refill_base  out  ADDR_W  block-aligned address: refill_addr with the low log2(BLOCK_WORDS) bits cleared.
- mem_req_valid  out  1  read request to main memory.
- mem_req_ready  in  1  memory accepts the request when valid && ready.
- mem_req_addr  out  ADDR_W  word address being read.
- mem_rsp_valid  in  1  read data returned; may arrive 1 or more cycles after the request is accepted.
- mem_rsp_data  in  WORD_W  read data.

Behaviour:
- Reset (synchronous, sampled at the clock edge):
  - State goes to IDLE; word counter and all registers clear to 0.
  - Outputs: refill_ready=1 after the reset edge; crit_valid, refill_done and mem_req_valid = 0; crit_data, refill_line, refill_base and mem_req_addr = 0.
- States:
  - IDLE: refill_ready=1. On accept, latch base and offset (off = refill_addr[1:0] for BLOCK_WORDS=4), clear the counter, go to REQ.
  - REQ: mem_req_valid=1 and mem_req_addr = base + ((off + cnt) mod BLOCK_WORDS). Hold valid and addr stable until mem_req_ready, then go to WAIT.
  - WAIT: mem_req_valid=0. On mem_rsp_valid:
    - write the word into line slot (off+cnt) mod BLOCK_WORDS;
    - if cnt==0, pulse crit_valid next cycle with crit_data = the word;
    - increment cnt; if cnt was BLOCK_WORDS-1, go to DONE, else go to REQ.
  - DONE: refill_done=1 for exactly this cycle; refill_line and refill_base are held until the next accept. Then go to IDLE.
- Latency with a zero-wait memory (ready=1, response 1 cycle after accept):
  - Accept at cycle N; requests at N+1, N+3, N+5, N+7; responses at N+2, N+4, N+6, N+8.
  - crit_valid at N+3, refill_done at N+9.
  - Next accept possible at N+10.
- Address arithmetic:
  - Word index = (off+cnt) & (BLOCK_WORDS-1); wrap stays inside the block, e.g. off=3 reads 3,0,1,2.
  - Address addition is modulo 2^ADDR_W. base is aligned, so no carry out of the block is possible.
- Boundary conditions:
  - refill_req while not IDLE: ignored, no queuing; the cache must hold the request until refill_ready.
  - mem_rsp_valid outside WAIT: ignored, covering stale or late data.
  - mem_rsp_valid in the same cycle as the request is accepted: not possible by protocol; a response is only sampled in WAIT.
  - mem_req_ready low: stall indefinitely in REQ; no timeout.
  - refill_req asserted during DONE: not accepted until IDLE.
  - Reset mid-refill: abort, drop the partial line, never pulse refill_done. A response arriving after reset is ignored.
  - Reset and refill_req in the same cycle: reset wins, the request is not accepted.

Decomposition:
- Package cache_pkg holds:
  - WORD_W, BLOCK_WORDS, ADDR_W and OFF_W = $clog2(BLOCK_WORDS);
  - typedef cache_line_t (logic [WORD_W*BLOCK_WORDS-1:0]);
  - enum refill_state_t {RF_IDLE, RF_REQ, RF_WAIT, RF_DONE}.
  - The cache imports the same package.
- No sub-module: one FSM plus a line register.

Test Plan:
- Aligned refill: addr 0x100, memory returns addr*3 with ready=1 and 1-cycle latency.
  - Request addresses are 0x100..0x103.
  - crit_data=0x300 at N+3; refill_done at N+9; line = {0x309, 0x306, 0x303, 0x300}; base = 0x100.
- Wrapped refill: addr 0x203.
  - Request order is 0x203, 0x200, 0x201, 0x202; crit_data = 0x609.
  - line slot 0 = 0x600 and slot 3 = 0x609; base = 0x200.
- Backpressure: mem_req_ready low for 5 cycles on the second word, and responses delayed 3 cycles.
  - mem_req_valid and mem_req_addr stay stable while stalled; the line is correct; refill_done arrives 7 cycles later than the zero-wait case.
- Busy request and spurious response: refill_req held during a refill, and a mem_rsp_valid pulse injected in IDLE and in REQ.
  - No second accept until IDLE; refill_ready=0 while busy; spurious data never appears in the line.
- Reset mid-refill: assert reset after the second response, then a late mem_rsp_valid arrives.
  - No refill_done; state is IDLE; refill_ready=1; the late response is ignored.
  - A following refill of 0x100 completes with the correct line.
- Address wrap: addr 0xFFFFFFFE.
  - Base is 0xFFFFFFFC; order is ...FE, ...FF, ...FC, ...FD; no address escapes the block.
